// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- RISC-V instruction decode stage.
//
// Decodes the instruction held in IF/ID combinationally, drives the register
// file / CSR read addresses, and captures the decoded operands into a single
// output register slice when the instruction is accepted. A three-state
// control FSM (EMPTY / FULL / BUBBLE) handles backpressure from EX, inserts a
// one-cycle bubble on a load-use hazard and drains on a flush from EX.
//
// Optional feature: define ID_STAGE_CSR_EN to decode Zicsr instructions.
// Without it, SYSTEM-opcode CSR instructions decode as illegal and the CSR
// address/data paths are tied to zero.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   inst_valid_i        IF/ID holds an instruction
//   inst_i/inst_addr_i  instruction word and its PC
//   inst_ready_o        instruction accepted this cycle
//   reg1/2_raddr_o      combinational register-file read addresses
//   reg1/2_rdata_i      same-cycle register-file read data
//   csr_raddr_o         combinational CSR read address
//   csr_rdata_i         same-cycle CSR read data
//   ex_ready_i          EX accepts the held instruction
//   ex_jump_flag_i      flush request from EX
//   valid_o ... stall_cnt_o  registered decode results towards EX
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [XLEN-1:0]   inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic              inst_ready_o,
  output logic [REG_AW-1:0] reg1_raddr_o,
  output logic [REG_AW-1:0] reg2_raddr_o,
  input  logic [XLEN-1:0]   reg1_rdata_i,
  input  logic [XLEN-1:0]   reg2_rdata_i,
  output logic [CSR_AW-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  input  logic              ex_ready_i,
  input  logic              ex_jump_flag_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [XLEN-1:0]   op1_jump_o,
  output logic [XLEN-1:0]   op2_jump_o,
  output logic [XLEN-1:0]   reg1_rdata_o,
  output logic [XLEN-1:0]   reg2_rdata_o,
  output logic [XLEN-1:0]   csr_rdata_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              rd_we_o,
  output logic              illegal_o,
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

  state_t state;
  logic   held_load;

  function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

  function automatic logic signed [XLEN-1:0] sext13(input logic [12:0] v);
    return {{(XLEN-13){v[12]}}, v};
  endfunction

  function automatic logic signed [XLEN-1:0] sext21(input logic [20:0] v);
    return {{(XLEN-21){v[20]}}, v};
  endfunction

  // ---- stage p0: combinational decode of inst_i ----
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1_f, rs2_f, rd_f;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rs1_f  = REG_AW'(inst_i[19:15]);
  assign rs2_f  = REG_AW'(inst_i[24:20]);
  assign rd_f   = REG_AW'(inst_i[11:7]);

  logic            legal_p0, rs1_rd_p0, rs2_rd_p0, rd_wr_p0;
  logic            is_load_p0, jalr_p0, csr_p0;
  logic [XLEN-1:0] op1_p0, op2_p0, op1_jump_p0, op2_jump_p0;

  // Every field stays zero unless a legal class sets it, so an unrecognised
  // encoding falls out with all operands and read addresses cleared.
  always_comb begin
    legal_p0    = 1'b0;
    rs1_rd_p0   = 1'b0;
    rs2_rd_p0   = 1'b0;
    rd_wr_p0    = 1'b0;
    is_load_p0  = 1'b0;
    jalr_p0     = 1'b0;
    csr_p0      = 1'b0;
    op1_p0      = '0;
    op2_p0      = '0;  // no instruction class drives op2
    op1_jump_p0 = '0;
    op2_jump_p0 = '0;
    case (opcode)
      7'b0110111, 7'b0010111: begin  // LUI / AUIPC
        legal_p0 = 1'b1;
        rd_wr_p0 = 1'b1;
        op1_p0   = XLEN'({inst_i[31:12], 12'b0});
      end
      7'b1101111: begin  // JAL
        legal_p0    = 1'b1;
        rd_wr_p0    = 1'b1;
        op1_jump_p0 = inst_addr_i;
        op2_jump_p0 = sext21({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0});
      end
      7'b1100111: begin  // JALR; op1_jump is muxed from rs1 data at capture
        if (funct3 == 3'b000) begin
          legal_p0    = 1'b1;
          rd_wr_p0    = 1'b1;
          rs1_rd_p0   = 1'b1;
          jalr_p0     = 1'b1;
          op2_jump_p0 = sext12(inst_i[31:20]);
        end
      end
      7'b1100011: begin  // branches
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          legal_p0    = 1'b1;
          rs1_rd_p0   = 1'b1;
          rs2_rd_p0   = 1'b1;
          op1_jump_p0 = inst_addr_i;
          op2_jump_p0 = sext13({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0});
        end
      end
      7'b0000011: begin  // loads
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          legal_p0   = 1'b1;
          rd_wr_p0   = 1'b1;
          rs1_rd_p0  = 1'b1;
          is_load_p0 = 1'b1;
          op1_p0     = sext12(inst_i[31:20]);
        end
      end
      7'b0100011: begin  // stores
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
          legal_p0  = 1'b1;
          rs1_rd_p0 = 1'b1;
          rs2_rd_p0 = 1'b1;
          op1_p0    = sext12({inst_i[31:25], inst_i[11:7]});
        end
      end
      7'b0010011: begin  // I-type ALU; shift-immediates constrain funct7
        if ((funct3 == 3'b001 && funct7 == 7'b0000000) ||
            (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
            (funct3 != 3'b001 && funct3 != 3'b101)) begin
          legal_p0  = 1'b1;
          rd_wr_p0  = 1'b1;
          rs1_rd_p0 = 1'b1;
          op1_p0    = sext12(inst_i[31:20]);
        end
      end
      7'b0110011: begin  // R-type ALU
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          legal_p0  = 1'b1;
          rd_wr_p0  = 1'b1;
          rs1_rd_p0 = 1'b1;
          rs2_rd_p0 = 1'b1;
        end
      end
      7'b0001111: begin  // FENCE: continue at PC + 4
        if (funct3 == 3'b000) begin
          legal_p0    = 1'b1;
          op1_jump_p0 = inst_addr_i;
          op2_jump_p0 = XLEN'(4);
        end
      end
`ifdef ID_STAGE_CSR_EN
      7'b1110011: begin  // Zicsr
        if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) begin
          legal_p0  = 1'b1;
          rd_wr_p0  = 1'b1;
          rs1_rd_p0 = 1'b1;
          csr_p0    = 1'b1;
        end else if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
          legal_p0 = 1'b1;
          rd_wr_p0 = 1'b1;
          csr_p0   = 1'b1;
          op1_p0   = XLEN'(inst_i[19:15]);  // uimm, zero-extended
        end
      end
`endif
      default: ;
    endcase
  end

  assign reg1_raddr_o = rs1_rd_p0 ? rs1_f : '0;
  assign reg2_raddr_o = rs2_rd_p0 ? rs2_f : '0;

  logic [XLEN-1:0] csr_data_p0;
`ifdef ID_STAGE_CSR_EN
  assign csr_raddr_o = csr_p0 ? CSR_AW'(inst_i[31:20]) : '0;
  assign csr_data_p0 = csr_p0 ? csr_rdata_i : '0;
`else
  logic csr_unused;
  assign csr_raddr_o = '0;
  assign csr_data_p0 = '0;
  assign csr_unused  = ^{csr_rdata_i, csr_p0};
`endif

  // Load-use: the held load's rd matches a source register the incoming
  // instruction really reads, so it must wait one cycle for the load data.
  logic hazard, accept;

  assign hazard = (state == FULL) && held_load && (rd_o != '0) &&
                  ((rs1_rd_p0 && rs1_f == rd_o) || (rs2_rd_p0 && rs2_f == rd_o));

  // A flush drains IF/ID, so the stage reports ready regardless of stalls.
  assign inst_ready_o = ex_jump_flag_i | ((!valid_o || ex_ready_i) && !hazard);
  assign accept       = inst_valid_i && inst_ready_o && !ex_jump_flag_i;

  // ---- stage p1: output register and control FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= EMPTY;
      valid_o      <= 1'b0;
      held_load    <= 1'b0;
      inst_o       <= '0;
      inst_addr_o  <= '0;
      op1_o        <= '0;
      op2_o        <= '0;
      op1_jump_o   <= '0;
      op2_jump_o   <= '0;
      reg1_rdata_o <= '0;
      reg2_rdata_o <= '0;
      csr_rdata_o  <= '0;
      rd_o         <= '0;
      rd_we_o      <= 1'b0;
      illegal_o    <= 1'b0;
    end else if (ex_jump_flag_i) begin
      state   <= EMPTY;
      valid_o <= 1'b0;
    end else if (hazard && ex_ready_i) begin
      // the load moves on to EX; leave a bubble behind it
      state   <= BUBBLE;
      valid_o <= 1'b0;
    end else if (accept) begin
      state        <= FULL;
      valid_o      <= 1'b1;
      held_load    <= is_load_p0;
      inst_o       <= inst_i;
      inst_addr_o  <= inst_addr_i;
      op1_o        <= op1_p0;
      op2_o        <= op2_p0;
      op1_jump_o   <= jalr_p0 ? reg1_rdata_i : op1_jump_p0;
      op2_jump_o   <= op2_jump_p0;
      reg1_rdata_o <= rs1_rd_p0 ? reg1_rdata_i : '0;
      reg2_rdata_o <= rs2_rd_p0 ? reg2_rdata_i : '0;
      csr_rdata_o  <= csr_data_p0;
      rd_o         <= rd_wr_p0 ? rd_f : '0;
      rd_we_o      <= rd_wr_p0 && (rd_f != '0);
      illegal_o    <= !legal_p0;
    end else if (state != FULL || ex_ready_i) begin
      state   <= EMPTY;
      valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (inst_valid_i && !inst_ready_o && stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- directed self-checking bench for id_stage.
// The register file and CSR file are modelled as pure functions of the read
// address so expected read data can be written down by hand.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] inst_i, inst_addr_i;
  logic        inst_ready_o;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i;
  logic [11:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic        ex_ready_i, ex_jump_flag_i;
  logic        valid_o;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o;
  logic [31:0] reg1_rdata_o, reg2_rdata_o, csr_rdata_o;
  logic [4:0]  rd_o;
  logic        rd_we_o, illegal_o;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDI_X1_X2_M1 = 32'hFFF1_0093;
  localparam logic [31:0] BEQ_X1_X2_M8  = 32'hFE20_8CE3;
  localparam logic [31:0] JAL_X1_16     = 32'h0100_00EF;
  localparam logic [31:0] LUI_X3        = 32'h1234_51B7;
  localparam logic [31:0] SW_X2_8_X1    = 32'h0020_A423;
  localparam logic [31:0] BAD_OPCODE    = 32'hFFFF_FFFF;
  localparam logic [31:0] CSRRW_X1_X2   = 32'h3001_10F3;
  localparam logic [31:0] LW_X5_0_X1    = 32'h0000_A283;
  localparam logic [31:0] ADD_X6_X5_X0  = 32'h0002_8333;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  assign reg1_rdata_i = 32'hA000_0000 | 32'(reg1_raddr_o);
  assign reg2_rdata_i = 32'hB000_0000 | 32'(reg2_raddr_o);
  assign csr_rdata_i  = 32'hC000_0000 | 32'(csr_raddr_o);

  id_stage dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .inst_ready_o(inst_ready_o),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .ex_ready_i(ex_ready_i), .ex_jump_flag_i(ex_jump_flag_i),
    .valid_o(valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
    .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o), .csr_rdata_o(csr_rdata_o),
    .rd_o(rd_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    inst_valid_i = 1'b1;
    inst_i       = inst;
    inst_addr_i  = pc;
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    inst_valid_i   = 1'b0;
    inst_i         = '0;
    inst_addr_i    = '0;
    ex_ready_i     = 1'b0;
    ex_jump_flag_i = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);
    chk("rst_rd_we", 32'(rd_we_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_op1", op1_o, 32'd0);
    rst = 1'b1;

    // ADDI x1, x2, -1
    ex_ready_i = 1'b1;
    present(ADDI_X1_X2_M1, 32'h0000_0000);
    chk("addi_raddr1", 32'(reg1_raddr_o), 32'd2);
    chk("addi_raddr2", 32'(reg2_raddr_o), 32'd0);
    chk("addi_ready", 32'(inst_ready_o), 32'd1);
    tick();
    chk("addi_valid", 32'(valid_o), 32'd1);
    chk("addi_op1", op1_o, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(rd_o), 32'd1);
    chk("addi_rd_we", 32'(rd_we_o), 32'd1);
    chk("addi_rdata1", reg1_rdata_o, 32'hA000_0002);
    chk("addi_illegal", 32'(illegal_o), 32'd0);

    // BEQ x1, x2, -8 at 0x100
    present(BEQ_X1_X2_M8, 32'h0000_0100);
    tick();
    chk("beq_op1_jump", op1_jump_o, 32'h0000_0100);
    chk("beq_op2_jump", op2_jump_o, 32'hFFFF_FFF8);
    chk("beq_rd_we", 32'(rd_we_o), 32'd0);
    chk("beq_rd", 32'(rd_o), 32'd0);
    chk("beq_op1", op1_o, 32'd0);
    chk("beq_rdata2", reg2_rdata_o, 32'hB000_0002);

    // JAL x1, +16 at 0x200
    present(JAL_X1_16, 32'h0000_0200);
    chk("jal_raddr1", 32'(reg1_raddr_o), 32'd0);
    tick();
    chk("jal_op1_jump", op1_jump_o, 32'h0000_0200);
    chk("jal_op2_jump", op2_jump_o, 32'h0000_0010);
    chk("jal_rd_we", 32'(rd_we_o), 32'd1);

    // LUI x3, 0x12345
    present(LUI_X3, 32'h0000_0204);
    tick();
    chk("lui_op1", op1_o, 32'h1234_5000);
    chk("lui_op1_jump", op1_jump_o, 32'd0);
    chk("lui_rd", 32'(rd_o), 32'd3);

    // SW x2, 8(x1)
    present(SW_X2_8_X1, 32'h0000_0208);
    tick();
    chk("sw_op1", op1_o, 32'h0000_0008);
    chk("sw_rd_we", 32'(rd_we_o), 32'd0);
    chk("sw_rdata2", reg2_rdata_o, 32'hB000_0002);

    // unrecognised opcode still travels down, flagged illegal
    present(BAD_OPCODE, 32'h0000_020C);
    tick();
    chk("bad_valid", 32'(valid_o), 32'd1);
    chk("bad_illegal", 32'(illegal_o), 32'd1);
    chk("bad_rd_we", 32'(rd_we_o), 32'd0);
    chk("bad_op1_jump", op1_jump_o, 32'd0);

    // CSRRW x1, 0x300, x2
    present(CSRRW_X1_X2, 32'h0000_0210);
`ifdef ID_STAGE_CSR_EN
    chk("csr_raddr", 32'(csr_raddr_o), 32'h0000_0300);
    tick();
    chk("csr_illegal", 32'(illegal_o), 32'd0);
    chk("csr_rdata", csr_rdata_o, 32'hC000_0300);
`else
    chk("csr_raddr", 32'(csr_raddr_o), 32'd0);
    tick();
    chk("csr_illegal", 32'(illegal_o), 32'd1);
    chk("csr_rd_we", 32'(rd_we_o), 32'd0);
    chk("csr_rdata", csr_rdata_o, 32'd0);
`endif

    // backpressure: EX stalls three cycles while the CSRRW is held
    ex_ready_i = 1'b0;
    present(ADDI_X1_X2_M1, 32'h0000_0214);
    chk("bp_ready", 32'(inst_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_inst_hold", inst_o, CSRRW_X1_X2);
      chk("bp_valid_hold", 32'(valid_o), 32'd1);
    end
    chk("bp_stall_cnt", stall_cnt_o, 32'd3);

    // load-use: LW x5 then ADD x6, x5, x0
    ex_ready_i = 1'b1;
    present(LW_X5_0_X1, 32'h0000_0300);
    tick();
    chk("lw_rd", 32'(rd_o), 32'd5);
    chk("lw_valid", 32'(valid_o), 32'd1);
    present(ADD_X6_X5_X0, 32'h0000_0304);
    chk("lu_ready", 32'(inst_ready_o), 32'd0);
    chk("lu_raddr1", 32'(reg1_raddr_o), 32'd5);
    tick();
    chk("lu_bubble_valid", 32'(valid_o), 32'd0);
    chk("lu_stall_cnt", stall_cnt_o, 32'd4);
    chk("lu_bubble_ready", 32'(inst_ready_o), 32'd1);
    tick();
    chk("lu_add_valid", 32'(valid_o), 32'd1);
    chk("lu_add_inst", inst_o, ADD_X6_X5_X0);
    chk("lu_add_rd", 32'(rd_o), 32'd6);
    chk("lu_add_rdata1", reg1_rdata_o, 32'hA000_0005);

    // flush while FULL with a valid instruction waiting
    ex_jump_flag_i = 1'b1;
    present(ADDI_X1_X2_M1, 32'h0000_0400);
    chk("fl_ready", 32'(inst_ready_o), 32'd1);
    tick();
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_inst_kept", inst_o, ADD_X6_X5_X0);
    chk("fl_addr_kept", inst_addr_o, 32'h0000_0304);
    chk("fl_stall_cnt", stall_cnt_o, 32'd4);
    ex_jump_flag_i = 1'b0;
    tick();
    chk("post_fl_valid", 32'(valid_o), 32'd1);
    chk("post_fl_addr", inst_addr_o, 32'h0000_0400);

    // NOP writes x0: no register write
    present(NOP, 32'h0000_0404);
    tick();
    chk("nop_rd_we", 32'(rd_we_o), 32'd0);

    // reset asserted in the middle of a stall
    present(LW_X5_0_X1, 32'h0000_0408);
    tick();
    ex_ready_i = 1'b0;
    present(ADD_X6_X5_X0, 32'h0000_040C);
    tick();
    chk("pre_rst_stall", stall_cnt_o, 32'd5);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_stall", stall_cnt_o, 32'd0);
    chk("arst_inst", inst_o, 32'd0);
    chk("arst_addr", inst_addr_o, 32'd0);
    chk("arst_rd", 32'(rd_o), 32'd0);
    chk("arst_rd_we", 32'(rd_we_o), 32'd0);
    inst_valid_i = 1'b0;
    ex_ready_i   = 1'b1;
    #1;
    rst = 1'b1;
    tick();
    chk("post_rst_valid", 32'(valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
